// File: rtl/level_clk_sel_pkg.sv
// Shared definitions for the level-clock selector and the divider bank:
// switch-state encoding, default channel count and switch timeout, and a
// helper that decides whether a requested level exists.
package level_clk_sel_pkg;

   // Switch state machine encoding.
   typedef enum logic [1:0] {
      RUN      = 2'd0,
      HOLD_OLD = 2'd1,
      WAIT_NEW = 2'd2
   } lcs_state_e;

   // Defaults shared with the divider bank.
   localparam int LCS_N_CH    = 4;
   localparam int LCS_TIMEOUT = 1023;

   // A level request is only meaningful when it names an existing source.
   function automatic logic sel_valid(input int unsigned sel, input int unsigned n_ch);
      return (sel < n_ch);
   endfunction

endpackage

// File: rtl/level_clk_sel_edge_tick.sv
// Registered rising-edge pulse generator. Registers the incoming level and,
// in the same cycle, a one-cycle pulse that is high when the level being
// registered is 1 and the level currently held is 0. Also used by the
// sequencer for button edges.
module edge_tick (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic d_i,
   output logic q_o,
   output logic tick_o
);

   logic q_q;
   logic tick_q;

   // Register the level and its rising-edge pulse together.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         q_q    <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         q_q    <= d_i;
         tick_q <= d_i & ~q_q;
      end
   end

   assign q_o    = q_q;
   assign tick_o = tick_q;

endmodule

// File: rtl/level_clk_sel.sv
// Glitch-free level-clock selector. Picks one of N_CH slow square-wave
// sources (all synchronous to CLK_i) and registers it onto CLKHZ_o, with a
// one-cycle rising-edge tick for the game sequencer. A level change first
// waits for the old source to go low, forces the output low, then waits for
// the new source to be low before handing over, so the output only ever
// shows complete high phases. A saturating counter bounds each wait so a
// stuck source cannot hang the switch.
module level_clk_sel
   import level_clk_sel_pkg::*;
#(
   parameter  int N_CH    = LCS_N_CH,
   parameter  int TIMEOUT = LCS_TIMEOUT,
   localparam int SEL_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic             CLK_i,
   input  logic             RSTN_i,
   input  logic [N_CH-1:0]  CL_i,
   input  logic [SEL_W-1:0] level_i,
   output logic             CLKHZ_o,
   output logic             tick_o,
   output logic [SEL_W-1:0] level_o,
   output logic             busy_o
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam int N_PAD = 1 << SEL_W;

   lcs_state_e       state_q;
   logic [SEL_W-1:0] level_q;
   logic [SEL_W-1:0] pend_q;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q;

   logic [N_PAD-1:0] cl_pad_s;
   logic             valid_s;
   logic [SEL_W-1:0] pend_n_s;
   logic             old_bit_s;
   logic             new_bit_s;
   logic             tmo_s;
   logic             withdraw_s;
   logic [CNT_W-1:0] cnt_inc_s;
   logic             clkhz_d;

   // Pad the source vector to a power of two so any select value indexes
   // a defined bit; padding bits read as 0.
   assign cl_pad_s = N_PAD'(CL_i);

   // Requests naming a non-existent level are ignored everywhere.
   assign valid_s = sel_valid(32'(level_i), 32'(N_CH));

   // Pending target after this cycle: a valid request always retargets.
   assign pend_n_s = valid_s ? level_i : pend_q;

   assign old_bit_s = cl_pad_s[level_q];
   assign new_bit_s = cl_pad_s[pend_n_s];

   // The wait ends on the TIMEOUT-th cycle spent in the switch state.
   assign tmo_s = (cnt_q >= CNT_W'(TIMEOUT - 1));

   // Saturating counter increment; it never wraps.
   assign cnt_inc_s = (cnt_q == CNT_W'(TIMEOUT)) ? cnt_q : (cnt_q + CNT_W'(1));

   // Request withdrawn while still showing the old source.
   assign withdraw_s = (state_q == HOLD_OLD) && valid_s && (level_i == level_q);

   // Next value of the output clock: follow the active source except while
   // the hand-over is in progress, where it is forced low.
   always_comb begin
      clkhz_d = 1'b0;
      case (state_q)
         RUN: begin
            clkhz_d = old_bit_s;
         end
         HOLD_OLD: begin
            if (withdraw_s) begin
               clkhz_d = old_bit_s;
            end else if (!old_bit_s || tmo_s) begin
               clkhz_d = 1'b0;
            end else begin
               clkhz_d = old_bit_s;
            end
         end
         WAIT_NEW: begin
            clkhz_d = 1'b0;
         end
         default: begin
            clkhz_d = 1'b0;
         end
      endcase
   end

   // Switch state machine with registered active level, pending level,
   // wait counter and busy flag.
   always_ff @(posedge CLK_i) begin
      if (!RSTN_i) begin
         state_q <= RUN;
         level_q <= '0;
         pend_q  <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (valid_s && (level_i != level_q)) begin
                  pend_q  <= level_i;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= HOLD_OLD;
               end
            end
            HOLD_OLD: begin
               if (withdraw_s) begin
                  busy_q  <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= RUN;
               end else begin
                  pend_q <= pend_n_s;
                  // Always pass through WAIT_NEW, even when the new source
                  // is already low, so at least one forced-low cycle occurs.
                  if (!old_bit_s || tmo_s) begin
                     cnt_q   <= '0;
                     state_q <= WAIT_NEW;
                  end else begin
                     cnt_q <= cnt_inc_s;
                  end
               end
            end
            WAIT_NEW: begin
               pend_q <= pend_n_s;
               // Hand over only while the new source is low, so the first
               // high seen on the output is a whole high phase.
               if (!new_bit_s || tmo_s) begin
                  level_q <= pend_n_s;
                  busy_q  <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= RUN;
               end else begin
                  cnt_q <= cnt_inc_s;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               cnt_q   <= '0;
               state_q <= RUN;
            end
         endcase
      end
   end

   // Output clock register and its rising-edge tick.
   edge_tick u_edge_tick (
      .clk_i  (CLK_i),
      .rstn_i (RSTN_i),
      .d_i    (clkhz_d),
      .q_o    (CLKHZ_o),
      .tick_o (tick_o)
   );

   assign level_o = level_q;
   assign busy_o  = busy_q;

endmodule

// File: tb/tb_level_clk_sel.sv
// Directed bench for level_clk_sel. Instance A (4 sources, long timeout)
// covers reset, steady select, glitch-free switch and retarget/abort.
// Instance B (3 sources, TIMEOUT=8) covers timeout, out-of-range requests
// and reset in the middle of a switch.
module tb_level_clk_sel;

   logic       clk = 1'b0;
   logic       rstn;

   logic [3:0] cl_a;
   logic [1:0] lvl_a;
   logic       clkhz_a;
   logic       tick_a;
   logic [1:0] lvlo_a;
   logic       busy_a;

   logic [2:0] cl_b;
   logic [1:0] lvl_b;
   logic       clkhz_b;
   logic       tick_b;
   logic [1:0] lvlo_b;
   logic       busy_b;

   int total = 0;
   int bad   = 0;
   int ticks;

   always #5 clk = ~clk;

   level_clk_sel #(.N_CH(4), .TIMEOUT(20)) dut_a (
      .CLK_i   (clk),
      .RSTN_i  (rstn),
      .CL_i    (cl_a),
      .level_i (lvl_a),
      .CLKHZ_o (clkhz_a),
      .tick_o  (tick_a),
      .level_o (lvlo_a),
      .busy_o  (busy_a)
   );

   level_clk_sel #(.N_CH(3), .TIMEOUT(8)) dut_b (
      .CLK_i   (clk),
      .RSTN_i  (rstn),
      .CL_i    (cl_b),
      .level_i (lvl_b),
      .CLKHZ_o (clkhz_b),
      .tick_o  (tick_b),
      .level_o (lvlo_b),
      .busy_o  (busy_b)
   );

   // Compare one observed value against its expected value.
   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are stable 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // ---------------- reset values ----------------
      rstn  = 1'b0;
      cl_a  = 4'b1111;
      lvl_a = 2'd2;
      cl_b  = 3'b000;
      lvl_b = 2'd0;
      repeat (3) step();
      check_eq("rst_clkhz_a", 16'(clkhz_a), 16'd0);
      check_eq("rst_tick_a",  16'(tick_a),  16'd0);
      check_eq("rst_level_a", 16'(lvlo_a),  16'd0);
      check_eq("rst_busy_a",  16'(busy_a),  16'd0);
      check_eq("rst_clkhz_b", 16'(clkhz_b), 16'd0);
      check_eq("rst_busy_b",  16'(busy_b),  16'd0);
      rstn = 1'b1;
      step();
      check_eq("rel_clkhz_a", 16'(clkhz_a), 16'd1);
      check_eq("rel_tick_a",  16'(tick_a),  16'd1);
      check_eq("rel_level_a", 16'(lvlo_a),  16'd0);
      check_eq("rel_busy_a",  16'(busy_a),  16'd1);

      // ---------------- steady select of level 1 ----------------
      rstn  = 1'b0;
      cl_a  = 4'b0000;
      lvl_a = 2'd1;
      repeat (2) step();
      rstn  = 1'b1;
      ticks = 0;
      for (int n = 0; n < 32; n++) begin
         cl_a    = 4'b0000;
         cl_a[1] = ((n / 4) % 2) == 1;
         step();
         if (n == 2) begin
            check_eq("sel_level", 16'(lvlo_a), 16'd1);
            check_eq("sel_busy",  16'(busy_a), 16'd0);
         end
         if (n >= 3) begin
            check_eq("sel_clkhz", 16'(clkhz_a), 16'(((n / 4) % 2) == 1));
            check_eq("sel_tick",  16'(tick_a),  16'((n % 8) == 4));
            if (tick_a) ticks++;
         end
      end
      check_eq("sel_tick_count", 16'(ticks), 16'd4);

      // ---------------- glitch-free switch 0 -> 2 ----------------
      rstn  = 1'b0;
      cl_a  = 4'b0000;
      lvl_a = 2'd0;
      repeat (2) step();
      rstn = 1'b1;
      for (int n = 0; n < 26; n++) begin
         cl_a    = 4'b0000;
         cl_a[0] = (n % 16) >= 8;
         cl_a[2] = (n % 6) >= 3;
         lvl_a   = (n >= 9) ? 2'd2 : 2'd0;
         step();
         check_eq("sw_clkhz", 16'(clkhz_a), 16'(((n >= 8) && (n <= 15)) || ((n >= 21) && (n <= 23))));
         check_eq("sw_tick",  16'(tick_a),  16'((n == 8) || (n == 21)));
         check_eq("sw_busy",  16'(busy_a),  16'((n >= 9) && (n <= 17)));
         check_eq("sw_level", 16'(lvlo_a),  (n >= 18) ? 16'd2 : 16'd0);
      end

      // ---------------- request withdrawn in HOLD_OLD ----------------
      rstn  = 1'b0;
      cl_a  = 4'b0001;
      lvl_a = 2'd0;
      repeat (2) step();
      rstn = 1'b1;
      for (int n = 0; n < 7; n++) begin
         lvl_a = ((n == 2) || (n == 3)) ? 2'd3 : 2'd0;
         step();
         check_eq("ab_clkhz", 16'(clkhz_a), 16'd1);
         check_eq("ab_busy",  16'(busy_a),  16'((n == 2) || (n == 3)));
         check_eq("ab_level", 16'(lvlo_a),  16'd0);
      end

      // ---------------- retarget 1 -> 3 in WAIT_NEW ----------------
      cl_a  = 4'b1010;
      lvl_a = 2'd1;
      step();
      step();
      check_eq("rt_clkhz_wait", 16'(clkhz_a), 16'd0);
      check_eq("rt_busy_wait",  16'(busy_a),  16'd1);
      lvl_a = 2'd3;
      step();
      check_eq("rt_busy_hold",  16'(busy_a),  16'd1);
      check_eq("rt_level_hold", 16'(lvlo_a),  16'd0);
      cl_a = 4'b0010;
      step();
      check_eq("rt_level", 16'(lvlo_a),  16'd3);
      check_eq("rt_busy",  16'(busy_a),  16'd0);
      check_eq("rt_clkhz", 16'(clkhz_a), 16'd0);
      cl_a = 4'b1010;
      step();
      check_eq("rt_clkhz_new", 16'(clkhz_a), 16'd1);
      check_eq("rt_tick_new",  16'(tick_a),  16'd1);

      // ---------------- timeout with stuck-high sources ----------------
      rstn  = 1'b0;
      cl_b  = 3'b001;
      lvl_b = 2'd0;
      repeat (2) step();
      rstn = 1'b1;
      step();
      check_eq("to_clkhz_run", 16'(clkhz_b), 16'd1);
      cl_b  = 3'b011;
      lvl_b = 2'd1;
      step();
      check_eq("to_busy_start", 16'(busy_b),  16'd1);
      check_eq("to_clkhz_start", 16'(clkhz_b), 16'd1);
      for (int k = 1; k <= 17; k++) begin
         step();
         check_eq("to_clkhz", 16'(clkhz_b), 16'((k <= 7) || (k == 17)));
         check_eq("to_level", 16'(lvlo_b),  (k >= 16) ? 16'd1 : 16'd0);
         check_eq("to_busy",  16'(busy_b),  16'(k <= 15));
         check_eq("to_tick",  16'(tick_b),  16'(k == 17));
      end

      // ---------------- out-of-range request ignored in RUN ----------------
      lvl_b = 2'd3;
      repeat (3) step();
      check_eq("inv_level", 16'(lvlo_b),  16'd1);
      check_eq("inv_busy",  16'(busy_b),  16'd0);
      check_eq("inv_clkhz", 16'(clkhz_b), 16'd1);

      // ---------------- invalid in WAIT_NEW, then reset mid-switch ----------------
      cl_b  = 3'b001;
      lvl_b = 2'd0;
      step();
      step();
      lvl_b = 2'd3;
      step();
      check_eq("mid_busy",  16'(busy_b),  16'd1);
      check_eq("mid_level", 16'(lvlo_b),  16'd1);
      check_eq("mid_clkhz", 16'(clkhz_b), 16'd0);
      rstn  = 1'b0;
      lvl_b = 2'd0;
      step();
      check_eq("mrst_clkhz", 16'(clkhz_b), 16'd0);
      check_eq("mrst_tick",  16'(tick_b),  16'd0);
      check_eq("mrst_level", 16'(lvlo_b),  16'd0);
      check_eq("mrst_busy",  16'(busy_b),  16'd0);
      rstn = 1'b1;
      step();
      check_eq("mrel_clkhz", 16'(clkhz_b), 16'd1);
      check_eq("mrel_tick",  16'(tick_b),  16'd1);
      check_eq("mrel_busy",  16'(busy_b),  16'd0);
      check_eq("mrel_level", 16'(lvlo_b),  16'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
